rs_multi_cdb: RTL and testbench
===============================

Name: rs_multi_cdb

Overview:
Parametrised next-generation reservation station between the decoder/issue stage and one execution unit.
- Holds up to RS_DEPTH renamed instructions and snoops CDB_N result broadcast channels for operand wakeup.
- Dispatches the oldest fully-ready entry to EX through a registered valid/ready output stage.
- Adds over the previous RS: multi-channel wakeup, wakeup at allocation, oldest-first selection, EX back-pressure, occupancy count.

Parameters:
RS_DEPTH, 16, number of entries (power of two, 2..32)
TAG_W, 4, ROB tag width; tag value 0 means "no dependency / operand ready"
DATA_W, 32, operand data width
IMM_W, 32, immediate width
ADDR_W, 32, PC width
OP_W, 6, op-type code width
CDB_N, 2, number of result broadcast channels

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
rdy  in  1  global enable; when low all state holds
clear  in  1  misprediction flush, synchronous
in_valid  in  1  decoder presents an instruction
in_ready  out  1  equals (count != RS_DEPTH)
in_dest  in  TAG_W  ROB tag of the instruction
in_op  in  OP_W  op type
in_q1 / in_q2  in  TAG_W  source tags (0 = value valid)
in_v1 / in_v2  in  DATA_W  source values
in_imm  in  IMM_W  immediate
in_pc  in  ADDR_W  PC
cdb_valid  in  CDB_N  per-channel broadcast valid
cdb_tag  in  CDB_N*TAG_W  channel k occupies bits [k*TAG_W +: TAG_W]
cdb_data  in  CDB_N*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W]
ex_valid  out  1  output register holds an instruction
ex_ready  in  1  EX accepts this cycle
ex_op, ex_v1, ex_v2, ex_imm, ex_pc, ex_dest  out  OP_W/DATA_W/DATA_W/IMM_W/ADDR_W/TAG_W  dispatched instruction
count  out  $clog2(RS_DEPTH)+1  occupied entries

Behaviour:
- Reset and clear (same cycle as asserted):
  - All entries invalid, count=0, ex_valid=0, all ex_* data outputs=0.
  - rst has priority over clear; clear has priority over all other activity, including a same-cycle allocation.
- rdy=0: no state changes; outputs hold their values.
- Allocation:
  - Occurs when in_valid && in_ready, into the lowest-index free entry.
  - Each entry records an age so that oldest-first is exact, including when slots are reused out of order.
- Wakeup at allocation:
  - If in_q1/in_q2 is nonzero and matches a valid CDB channel in the same cycle, the entry stores that cdb_data and Q=0.
- Wakeup of stored entries:
  - Every cycle, each valid entry with Qx == cdb_tag[k] (cdb_valid[k]=1, Qx!=0) captures cdb_data[k] and sets Qx=0.
  - Q1 and Q2 are checked independently; two channels may wake both operands of one entry in the same cycle.
  - Duplicate tags across channels: the lowest channel index wins.
- Ready: an entry is ready when it is valid, Q1==0 and Q2==0.
- Selection: the oldest ready entry; a newly allocated entry is not eligible in its allocation cycle.
- Dispatch (output-register load):
  - Enabled when !ex_valid || ex_ready.
  - If a ready entry exists, load its fields into ex_*, set ex_valid=1, and free the entry that cycle.
  - Otherwise, if ex_ready, clear ex_valid to 0.
  - ex_* is stable while ex_valid && !ex_ready.
- Latency: an entry ready at allocation reaches ex_valid 2 cycles after the allocation edge when EX is not stalled.
- count: +1 on allocation, -1 on dispatch; both in one cycle leaves it unchanged.
  - A full RS accepts nothing even if it dispatches that cycle (in_ready is derived from registered count only).
- The output register is not snooped by the CDB (its operands are already complete).

Optional Feature:
RS_WAKEUP_BYPASS_EN
- Defined:
  - An entry whose last outstanding operand is woken by the CDB this cycle is eligible for selection in the same cycle.
  - ex_v1/ex_v2 load the CDB data directly.
  - Broadcast-to-ex_valid latency is 1 cycle.
- Undefined:
  - Selection sees only state registered at the start of the cycle.
  - Broadcast-to-ex_valid latency is 2 cycles.
- Neither mode changes the allocation-cycle ineligibility rule.

Test Plan:
- Reset, then allocate op=3, dest=5, q1=q2=0, v1=10, v2=20 at cycle 0, ex_ready=1 → ex_valid=1 at cycle 2 with ex_v1=10, ex_v2=20, ex_dest=5; count returns to 0.
- Fill 16 entries, each with q1=7 → in_ready=0 at count=16. Then cdb_valid=01, cdb_tag=7, data=0xAB → all entries woken; dispatch in allocation order with dest values increasing; ex_v1=0xAB for each.
- Entry A (older) waits on tag 2, entry B (younger) waits on tag 3. Channel 1 broadcasts tag 3 one cycle, channel 0 broadcasts tag 2 the next → B dispatches first, then A.
- Hold ex_ready=0 for 5 cycles with 3 ready entries → ex_* constant, count=2. Release → the remaining two dispatch on consecutive cycles.
- Allocate with in_q2=9 while cdb broadcasts tag 9, data 0x55 the same cycle → entry dispatches with ex_v2=0x55 and never stalls.
- With 4 entries pending and ex_valid=1, assert clear together with in_valid → count=0, ex_valid=0 next cycle; the incoming instruction is not stored.

Source files
------------

// File: rtl/rs_multi_cdb.sv
// rs_multi_cdb: reservation station snooping CDB_N result channels; the oldest ready entry goes to EX through a valid/ready register.
// Optional macro RS_WAKEUP_BYPASS_EN lets an entry woken this cycle be selected in the same cycle.
module rs_multi_cdb #(
  parameter int RS_DEPTH = 16,
  parameter int TAG_W    = 4,
  parameter int DATA_W   = 32,
  parameter int IMM_W    = 32,
  parameter int ADDR_W   = 32,
  parameter int OP_W     = 6,
  parameter int CDB_N    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      clear,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [TAG_W-1:0]          in_dest,
  input  logic [OP_W-1:0]           in_op,
  input  logic [TAG_W-1:0]          in_q1,
  input  logic [TAG_W-1:0]          in_q2,
  input  logic [DATA_W-1:0]         in_v1,
  input  logic [DATA_W-1:0]         in_v2,
  input  logic [IMM_W-1:0]          in_imm,
  input  logic [ADDR_W-1:0]         in_pc,
  input  logic [CDB_N-1:0]          cdb_valid,
  input  logic [CDB_N*TAG_W-1:0]    cdb_tag,
  input  logic [CDB_N*DATA_W-1:0]   cdb_data,
  output logic                      ex_valid,
  input  logic                      ex_ready,
  output logic [OP_W-1:0]           ex_op,
  output logic [DATA_W-1:0]         ex_v1,
  output logic [DATA_W-1:0]         ex_v2,
  output logic [IMM_W-1:0]          ex_imm,
  output logic [ADDR_W-1:0]         ex_pc,
  output logic [TAG_W-1:0]          ex_dest,
  output logic [$clog2(RS_DEPTH):0] count
);
  localparam int IDX_W = $clog2(RS_DEPTH);
  localparam int CNT_W = IDX_W + 1;

  // {hit, data} from the lowest-numbered channel broadcasting a nonzero tag equal to q.
  function automatic logic [DATA_W:0] snoop(input logic [TAG_W-1:0] q, input logic [CDB_N-1:0] v,
                                            input logic [CDB_N*TAG_W-1:0] t, input logic [CDB_N*DATA_W-1:0] d);
    logic [DATA_W:0] res;
    res = '0;
    for (int k = CDB_N - 1; k >= 0; k--)
      if (v[k] && q != '0 && t[k*TAG_W +: TAG_W] == q)
        res = {1'b1, d[k*DATA_W +: DATA_W]};
    return res;
  endfunction

  logic [RS_DEPTH-1:0] r_valid;
  logic [OP_W-1:0]     r_op   [RS_DEPTH];
  logic [TAG_W-1:0]    r_dest [RS_DEPTH];
  logic [TAG_W-1:0]    r_q1   [RS_DEPTH];
  logic [TAG_W-1:0]    r_q2   [RS_DEPTH];
  logic [DATA_W-1:0]   r_v1   [RS_DEPTH];
  logic [DATA_W-1:0]   r_v2   [RS_DEPTH];
  logic [IMM_W-1:0]    r_imm  [RS_DEPTH];
  logic [ADDR_W-1:0]   r_pc   [RS_DEPTH];
  // r_older[j][i] set means entry j was allocated before entry i
  logic [RS_DEPTH-1:0] r_older [RS_DEPTH];
  logic [CNT_W-1:0]    r_count;
  logic                r_ex_valid;
  logic [OP_W-1:0]     r_ex_op;
  logic [DATA_W-1:0]   r_ex_v1, r_ex_v2;
  logic [IMM_W-1:0]    r_ex_imm;
  logic [ADDR_W-1:0]   r_ex_pc;
  logic [TAG_W-1:0]    r_ex_dest;

  logic [DATA_W:0]     w_wk1 [RS_DEPTH];
  logic [DATA_W:0]     w_wk2 [RS_DEPTH];
  logic [DATA_W-1:0]   w_op1 [RS_DEPTH];
  logic [DATA_W-1:0]   w_op2 [RS_DEPTH];
  logic [RS_DEPTH-1:0] w_blk [RS_DEPTH];
  logic [RS_DEPTH-1:0] w_rdy, w_sel;
  logic [DATA_W:0]     w_in_wk1, w_in_wk2;
  logic [IDX_W-1:0]    w_free_idx;
  logic                w_alloc, w_load;
  logic [OP_W-1:0]     w_sel_op;
  logic [DATA_W-1:0]   w_sel_v1, w_sel_v2;
  logic [IMM_W-1:0]    w_sel_imm;
  logic [ADDR_W-1:0]   w_sel_pc;
  logic [TAG_W-1:0]    w_sel_dest;

  for (genvar gi = 0; gi < RS_DEPTH; gi++) begin : g_ent
    assign w_wk1[gi] = snoop(r_q1[gi], cdb_valid, cdb_tag, cdb_data);
    assign w_wk2[gi] = snoop(r_q2[gi], cdb_valid, cdb_tag, cdb_data);
`ifdef RS_WAKEUP_BYPASS_EN
    assign w_rdy[gi] = r_valid[gi] && (r_q1[gi] == '0 || w_wk1[gi][DATA_W])
                                   && (r_q2[gi] == '0 || w_wk2[gi][DATA_W]);
    assign w_op1[gi] = w_wk1[gi][DATA_W] ? w_wk1[gi][DATA_W-1:0] : r_v1[gi];
    assign w_op2[gi] = w_wk2[gi][DATA_W] ? w_wk2[gi][DATA_W-1:0] : r_v2[gi];
`else
    assign w_rdy[gi] = r_valid[gi] && r_q1[gi] == '0 && r_q2[gi] == '0;
    assign w_op1[gi] = r_v1[gi];
    assign w_op2[gi] = r_v2[gi];
`endif
    for (genvar gj = 0; gj < RS_DEPTH; gj++) begin : g_age
      if (gj == gi) begin : g_self
        assign w_blk[gi][gj] = 1'b0;
      end else begin : g_other
        assign w_blk[gi][gj] = w_rdy[gj] && r_older[gj][gi];
      end
    end
    assign w_sel[gi] = w_rdy[gi] && !(|w_blk[gi]);
  end

  always_comb begin
    w_sel_op = '0; w_sel_v1 = '0; w_sel_v2 = '0;
    w_sel_imm = '0; w_sel_pc = '0; w_sel_dest = '0;
    for (int i = 0; i < RS_DEPTH; i++)
      if (w_sel[i]) begin
        w_sel_op   |= r_op[i];
        w_sel_v1   |= w_op1[i];
        w_sel_v2   |= w_op2[i];
        w_sel_imm  |= r_imm[i];
        w_sel_pc   |= r_pc[i];
        w_sel_dest |= r_dest[i];
      end
  end

  always_comb begin
    w_free_idx = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--)
      if (!r_valid[i]) w_free_idx = IDX_W'(i);
  end

  assign in_ready = r_count != CNT_W'(RS_DEPTH);
  assign w_alloc  = in_valid && in_ready && !clear;
  assign w_load   = (!r_ex_valid || ex_ready) && (|w_sel) && !clear;
  assign w_in_wk1 = snoop(in_q1, cdb_valid, cdb_tag, cdb_data);
  assign w_in_wk2 = snoop(in_q2, cdb_valid, cdb_tag, cdb_data);

  always_ff @(posedge clk) begin
    if (rst || (rdy && clear)) begin
      r_valid    <= '0;
      r_count    <= '0;
      r_ex_valid <= 1'b0;
      r_ex_op    <= '0; r_ex_v1 <= '0; r_ex_v2 <= '0;
      r_ex_imm   <= '0; r_ex_pc <= '0; r_ex_dest <= '0;
    end else if (rdy) begin
      r_valid <= (r_valid & ~(w_load ? w_sel : '0))
               | (w_alloc ? (RS_DEPTH'(1) << w_free_idx) : '0);
      r_count <= r_count + CNT_W'(w_alloc) - CNT_W'(w_load);
      if (w_load) begin
        r_ex_valid <= 1'b1;
        r_ex_op    <= w_sel_op;  r_ex_v1 <= w_sel_v1; r_ex_v2   <= w_sel_v2;
        r_ex_imm   <= w_sel_imm; r_ex_pc <= w_sel_pc; r_ex_dest <= w_sel_dest;
      end else if (ex_ready) begin
        r_ex_valid <= 1'b0;
      end
    end
  end

  // Payload and age state need no reset: r_valid gates every use.
  always_ff @(posedge clk) begin
    if (rdy && !rst) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (w_alloc && w_free_idx == IDX_W'(i)) begin
          r_op[i]   <= in_op;
          r_dest[i] <= in_dest;
          r_imm[i]  <= in_imm;
          r_pc[i]   <= in_pc;
          r_q1[i]   <= w_in_wk1[DATA_W] ? '0 : in_q1;
          r_v1[i]   <= w_in_wk1[DATA_W] ? w_in_wk1[DATA_W-1:0] : in_v1;
          r_q2[i]   <= w_in_wk2[DATA_W] ? '0 : in_q2;
          r_v2[i]   <= w_in_wk2[DATA_W] ? w_in_wk2[DATA_W-1:0] : in_v2;
          for (int j = 0; j < RS_DEPTH; j++)
            if (j != i) begin
              r_older[j][i] <= 1'b1;
              r_older[i][j] <= 1'b0;
            end
        end else begin
          if (w_wk1[i][DATA_W]) begin
            r_q1[i] <= '0;
            r_v1[i] <= w_wk1[i][DATA_W-1:0];
          end
          if (w_wk2[i][DATA_W]) begin
            r_q2[i] <= '0;
            r_v2[i] <= w_wk2[i][DATA_W-1:0];
          end
        end
      end
    end
  end

  assign ex_valid = r_ex_valid;
  assign ex_op    = r_ex_op;
  assign ex_v1    = r_ex_v1;
  assign ex_v2    = r_ex_v2;
  assign ex_imm   = r_ex_imm;
  assign ex_pc    = r_ex_pc;
  assign ex_dest  = r_ex_dest;
  assign count    = r_count;
endmodule

// File: tb/tb_rs_multi_cdb.sv
// tb_rs_multi_cdb: directed table, hand-written corner sequences and randomized traffic
// checked every cycle against a queue-based reference model (default build).
`timescale 1ns/1ps
module tb_rs_multi_cdb;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst, rdy, clear, in_valid, in_ready, ex_valid, ex_ready;
  logic [3:0]  in_dest, in_q1, in_q2, ex_dest;
  logic [5:0]  in_op, ex_op;
  logic [31:0] in_v1, in_v2, in_imm, in_pc, ex_v1, ex_v2, ex_imm, ex_pc;
  logic [1:0]  cdb_valid;
  logic [7:0]  cdb_tag;
  logic [63:0] cdb_data;
  logic [4:0]  count;

  always #5 clk = ~clk;

  rs_multi_cdb dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_dest(in_dest), .in_op(in_op),
    .in_q1(in_q1), .in_q2(in_q2), .in_v1(in_v1), .in_v2(in_v2), .in_imm(in_imm), .in_pc(in_pc),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op), .ex_v1(ex_v1), .ex_v2(ex_v2),
    .ex_imm(ex_imm), .ex_pc(ex_pc), .ex_dest(ex_dest), .count(count)
  );

  typedef struct {
    logic [5:0]  op;
    logic [3:0]  dest, q1, q2;
    logic [31:0] v1, v2, imm, pc;
  } ent_t;

  // Model: queue in allocation order, so the oldest ready entry is the first ready one found.
  ent_t m_q[$];
  logic m_exv;
  ent_t m_ex;
  int   total = 0;
  int   bad = 0;

  typedef struct {
    logic        iv;
    logic [3:0]  dest;
    logic [5:0]  op;
    logic [31:0] v1, v2;
    logic        exr;
    logic        e_valid;
    logic [4:0]  e_count;
    logic [3:0]  e_dest;
    logic [31:0] e_v1, e_v2;
  } vec_t;
  vec_t vt[7];

  function automatic vec_t mk(logic iv, logic [3:0] dest, logic [5:0] op, logic [31:0] v1, logic [31:0] v2,
                              logic exr, logic ev, logic [4:0] ecnt, logic [3:0] edest,
                              logic [31:0] ev1, logic [31:0] ev2);
    vec_t r;
    r.iv = iv; r.dest = dest; r.op = op; r.v1 = v1; r.v2 = v2; r.exr = exr;
    r.e_valid = ev; r.e_count = ecnt; r.e_dest = edest; r.e_v1 = ev1; r.e_v2 = ev2;
    return r;
  endfunction

  function automatic logic [32:0] m_snoop(logic [3:0] q);
    for (int k = 0; k < 2; k++)
      if (q != 4'd0 && cdb_valid[k] && cdb_tag[k*4 +: 4] == q) return {1'b1, cdb_data[k*32 +: 32]};
    return 33'd0;
  endfunction

  task automatic model_step();
    int pre;
    int pick;
    logic [32:0] w;
    ent_t e;
    if (rst || (rdy && clear)) begin
      m_q.delete();
      m_exv = 1'b0;
      m_ex = '{default: '0};
      return;
    end
    if (!rdy) return;
    pre = m_q.size();
    pick = -1;
    if (!m_exv || ex_ready) begin
      foreach (m_q[i]) if (pick < 0 && m_q[i].q1 == 4'd0 && m_q[i].q2 == 4'd0) pick = i;
      if (pick >= 0) begin
        m_ex = m_q[pick];
        m_exv = 1'b1;
        m_q.delete(pick);
        $display("dispatch dest=%0d op=%0d v1=%0h v2=%0h", m_ex.dest, m_ex.op, m_ex.v1, m_ex.v2);
      end else if (ex_ready) m_exv = 1'b0;
    end
    foreach (m_q[i]) begin
      w = m_snoop(m_q[i].q1);
      if (w[32]) begin m_q[i].q1 = 4'd0; m_q[i].v1 = w[31:0]; end
      w = m_snoop(m_q[i].q2);
      if (w[32]) begin m_q[i].q2 = 4'd0; m_q[i].v2 = w[31:0]; end
    end
    if (in_valid && pre != DEPTH) begin
      e.op = in_op; e.dest = in_dest; e.imm = in_imm; e.pc = in_pc;
      e.q1 = in_q1; e.v1 = in_v1; e.q2 = in_q2; e.v2 = in_v2;
      w = m_snoop(in_q1);
      if (w[32]) begin e.q1 = 4'd0; e.v1 = w[31:0]; end
      w = m_snoop(in_q2);
      if (w[32]) begin e.q2 = 4'd0; e.v2 = w[31:0]; end
      m_q.push_back(e);
    end
  endtask

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic check_model();
    chk("ex_valid", 32'(ex_valid), 32'(m_exv));
    chk("count", 32'(count), 32'(m_q.size()));
    chk("in_ready", 32'(in_ready), 32'(m_q.size() != DEPTH));
    chk("ex_op", 32'(ex_op), 32'(m_ex.op));
    chk("ex_dest", 32'(ex_dest), 32'(m_ex.dest));
    chk("ex_v1", ex_v1, m_ex.v1);
    chk("ex_v2", ex_v2, m_ex.v2);
    chk("ex_imm", ex_imm, m_ex.imm);
    chk("ex_pc", ex_pc, m_ex.pc);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic drive(input logic [3:0] dest, input logic [5:0] op, input logic [3:0] q1,
                       input logic [3:0] q2, input logic [31:0] v1, input logic [31:0] v2);
    in_valid = 1'b1; in_dest = dest; in_op = op; in_q1 = q1; in_q2 = q2;
    in_v1 = v1; in_v2 = v2; in_imm = v1 ^ 32'hFFFF_0000; in_pc = {26'd0, dest, 2'b00};
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; clear = 1'b0; in_valid = 1'b0; ex_ready = 1'b1;
    in_dest = '0; in_op = '0; in_q1 = '0; in_q2 = '0; in_v1 = '0; in_v2 = '0; in_imm = '0; in_pc = '0;
    cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
    m_exv = 1'b0; m_ex = '{default: '0};
    tick(); tick();
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_ex_v1", ex_v1, 32'd0);
    rst = 1'b0;

    // Latency and back-pressure table
    vt[0] = mk(1'b1, 4'd5, 6'd3, 32'd10, 32'd20, 1'b1, 1'b0, 5'd1, 4'd0, 32'd0,  32'd0);
    vt[1] = mk(1'b0, 4'd0, 6'd0, 32'd0,  32'd0,  1'b1, 1'b1, 5'd0, 4'd5, 32'd10, 32'd20);
    vt[2] = mk(1'b0, 4'd0, 6'd0, 32'd0,  32'd0,  1'b1, 1'b0, 5'd0, 4'd5, 32'd10, 32'd20);
    vt[3] = mk(1'b1, 4'd6, 6'd1, 32'd1,  32'd2,  1'b0, 1'b0, 5'd1, 4'd5, 32'd10, 32'd20);
    vt[4] = mk(1'b0, 4'd0, 6'd0, 32'd0,  32'd0,  1'b0, 1'b1, 5'd0, 4'd6, 32'd1,  32'd2);
    vt[5] = mk(1'b0, 4'd0, 6'd0, 32'd0,  32'd0,  1'b0, 1'b1, 5'd0, 4'd6, 32'd1,  32'd2);
    vt[6] = mk(1'b0, 4'd0, 6'd0, 32'd0,  32'd0,  1'b1, 1'b0, 5'd0, 4'd6, 32'd1,  32'd2);
    foreach (vt[n]) begin
      if (vt[n].iv) drive(vt[n].dest, vt[n].op, 4'd0, 4'd0, vt[n].v1, vt[n].v2);
      else in_valid = 1'b0;
      ex_ready = vt[n].exr;
      tick();
      chk($sformatf("tbl%0d_valid", n), 32'(ex_valid), 32'(vt[n].e_valid));
      chk($sformatf("tbl%0d_count", n), 32'(count), 32'(vt[n].e_count));
      chk($sformatf("tbl%0d_dest", n), 32'(ex_dest), 32'(vt[n].e_dest));
      chk($sformatf("tbl%0d_v1", n), ex_v1, vt[n].e_v1);
      chk($sformatf("tbl%0d_v2", n), ex_v2, vt[n].e_v2);
    end

    // Fill to capacity, broadcast tag 7, drain in allocation order
    ex_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      drive(4'(i), 6'(i), 4'd7, 4'd0, 32'(i), 32'(100 + i));
      tick();
    end
    chk("full_count", 32'(count), 32'd16);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    drive(4'd9, 6'd9, 4'd0, 4'd0, 32'd9, 32'd9);
    tick();
    chk("full_reject", 32'(count), 32'd16);
    in_valid = 1'b0; cdb_valid = 2'b01; cdb_tag = 8'h07; cdb_data = {32'h0, 32'hAB};
    tick();
    cdb_valid = 2'b00;
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      chk("drain_valid", 32'(ex_valid), 32'd1);
      chk("drain_dest", 32'(ex_dest), 32'(i));
      chk("drain_v1", ex_v1, 32'hAB);
    end
    tick();
    chk("drain_end_valid", 32'(ex_valid), 32'd0);
    chk("drain_end_count", 32'(count), 32'd0);

    // Younger entry woken first dispatches first
    drive(4'd1, 6'd1, 4'd2, 4'd0, 32'd0, 32'd0); tick();
    drive(4'd2, 6'd2, 4'd3, 4'd0, 32'd0, 32'd0); tick();
    in_valid = 1'b0; cdb_valid = 2'b10; cdb_tag = 8'h30; cdb_data = {32'h33, 32'h0};
    tick();
    cdb_valid = 2'b01; cdb_tag = 8'h02; cdb_data = {32'h0, 32'h22};
    tick();
    cdb_valid = 2'b00;
    chk("order_first_dest", 32'(ex_dest), 32'd2);
    chk("order_first_v1", ex_v1, 32'h33);
    tick();
    chk("order_second_dest", 32'(ex_dest), 32'd1);
    chk("order_second_v1", ex_v1, 32'h22);
    tick();
    chk("order_end_valid", 32'(ex_valid), 32'd0);

    // EX stall with three ready entries
    ex_ready = 1'b0;
    drive(4'd10, 6'd10, 4'd0, 4'd0, 32'd10, 32'd10); tick();
    drive(4'd11, 6'd11, 4'd0, 4'd0, 32'd11, 32'd11); tick();
    drive(4'd12, 6'd12, 4'd0, 4'd0, 32'd12, 32'd12); tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_dest", 32'(ex_dest), 32'd10);
      chk("stall_count", 32'(count), 32'd2);
    end
    ex_ready = 1'b1;
    tick(); chk("release_1", 32'(ex_dest), 32'd11);
    tick(); chk("release_2", 32'(ex_dest), 32'd12);
    tick(); chk("release_end", 32'(ex_valid), 32'd0);

    // Wakeup in the allocation cycle
    drive(4'd3, 6'd3, 4'd0, 4'd9, 32'd1, 32'h1234);
    cdb_valid = 2'b01; cdb_tag = 8'h09; cdb_data = {32'h0, 32'h55};
    tick();
    in_valid = 1'b0; cdb_valid = 2'b00;
    chk("allocwake_count", 32'(count), 32'd1);
    tick();
    chk("allocwake_valid", 32'(ex_valid), 32'd1);
    chk("allocwake_v2", ex_v2, 32'h55);
    tick();

    // Flush with a same-cycle allocation
    ex_ready = 1'b0;
    drive(4'd4, 6'd4, 4'd0, 4'd0, 32'd4, 32'd4); tick();
    for (int i = 0; i < 4; i++) begin
      drive(4'(5 + i), 6'd5, 4'd15, 4'd0, 32'd5, 32'd5);
      tick();
    end
    chk("preflush_count", 32'(count), 32'd4);
    chk("preflush_valid", 32'(ex_valid), 32'd1);
    clear = 1'b1;
    drive(4'd13, 6'd13, 4'd0, 4'd0, 32'd13, 32'd13);
    tick();
    clear = 1'b0; in_valid = 1'b0;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_valid", 32'(ex_valid), 32'd0);
    chk("flush_dest", 32'(ex_dest), 32'd0);
    cdb_valid = 2'b01; cdb_tag = 8'h0F; cdb_data = 64'h77;
    tick();
    cdb_valid = 2'b00;
    tick();
    chk("postflush_count", 32'(count), 32'd0);
    chk("postflush_valid", 32'(ex_valid), 32'd0);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 399) == 0);
      rdy = ($urandom_range(0, 9) != 0);
      clear = ($urandom_range(0, 59) == 0);
      in_valid = 1'($urandom_range(0, 1));
      in_dest = 4'($urandom); in_op = 6'($urandom);
      in_q1 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 7));
      in_q2 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 7));
      in_v1 = $urandom; in_v2 = $urandom; in_imm = $urandom; in_pc = $urandom;
      cdb_valid = 2'($urandom);
      cdb_tag = {4'($urandom_range(1, 7)), 4'($urandom_range(1, 7))};
      cdb_data = {$urandom, $urandom};
      ex_ready = ($urandom_range(0, 9) < 7);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
